// File: rtl/universal_bin_counter_pkg.sv
// Shared constants for the universal binary counter.
package universal_bin_counter_pkg;

    localparam int unsigned COUNTER_W_DEFAULT = 8;

endpackage

// File: rtl/universal_bin_counter.sv
// N-bit synchronous up/down counter with clear, parallel load, enable and
// terminal-count flags decoded from the count register.
module universal_bin_counter
    import universal_bin_counter_pkg::*;
#(
    parameter int unsigned N = COUNTER_W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic [N-1:0] d,
    input  logic         syn_clr,
    input  logic         load,
    output logic         max_tick,
    output logic         min_tick,
    output logic [N-1:0] q
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    // Next-state mux: clear beats load, load beats counting.
    always_comb begin
        q_d = q_q;
        if (syn_clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = d;
        end else if (en) begin
            q_d = up ? q_q + N'(1) : q_q - N'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q        = q_q;
    assign max_tick = &q_q;
    assign min_tick = ~|q_q;

endmodule

// File: tb/tb_universal_bin_counter.sv
// Randomized and directed check of universal_bin_counter (N=3) against a
// modular-arithmetic reference model.
module tb_universal_bin_counter;

    localparam int unsigned N   = 3;
    localparam int          MOD = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         up;
    logic [N-1:0] d;
    logic         syn_clr;
    logic         load;
    logic         max_tick;
    logic         min_tick;
    logic [N-1:0] q;

    int n_vec = 0;
    int n_err = 0;
    int model = 0;

    universal_bin_counter #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .d        (d),
        .syn_clr  (syn_clr),
        .load     (load),
        .max_tick (max_tick),
        .min_tick (min_tick),
        .q        (q)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of controls, advance the model on the edge, check outputs.
    task automatic apply(input string tag, input logic r, input logic c, input logic l,
                         input logic e, input logic u, input int dv);
        reset   = r;
        syn_clr = c;
        load    = l;
        en      = e;
        up      = u;
        d       = N'(dv);
        @(posedge clk);
        if (r || c)      model = 0;
        else if (l)      model = dv % MOD;
        else if (e && u) model = (model + 1) % MOD;
        else if (e)      model = (model + MOD - 1) % MOD;
        #1;
        check_eq({tag, ".q"},        32'(q),        32'(model));
        check_eq({tag, ".max_tick"}, 32'(max_tick), 32'(model == MOD - 1));
        check_eq({tag, ".min_tick"}, 32'(min_tick), 32'(model == 0));
    endtask

    initial begin
        // Reset with other inputs arbitrary.
        apply("reset", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5);
        check_eq("reset.const", 32'(q), 32'd0);

        // Constant load of 2 with en/up active.
        for (int i = 0; i < 4; i++) begin
            apply("cload", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2);
            check_eq("cload.const", 32'(q), 32'd2);
        end

        // Up-count wrap from 0.
        apply("upclr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 1; i <= 9; i++) begin
            apply("upwrap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
            check_eq("upwrap.const", 32'(q), 32'(i % MOD));
        end

        // Down-count wrap from 0.
        apply("dnclr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 1; i <= 9; i++) begin
            apply("dnwrap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
            check_eq("dnwrap.const", 32'(q), 32'((MOD - (i % MOD)) % MOD));
        end

        // Priority: clear beats load, load beats count, en=0 holds.
        apply("prio.ld5", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5);
        apply("prio.clr", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3);
        check_eq("prio.clr.const", 32'(q), 32'd0);
        apply("prio.ld6", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6);
        check_eq("prio.ld6.const", 32'(q), 32'd6);
        for (int i = 0; i < 3; i++) begin
            apply("prio.hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
            check_eq("prio.hold.const", 32'(q), 32'd6);
        end

        // Reset mid-count overrides load, then counting resumes from 0.
        apply("mid.ld4", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4);
        apply("mid.rst", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 7);
        check_eq("mid.rst.const", 32'(q), 32'd0);
        apply("mid.go", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        check_eq("mid.go.const", 32'(q), 32'd1);

        // Random traffic with sparse reset/clear/load.
        for (int i = 0; i < 400; i++) begin
            apply("rand",
                  1'($urandom_range(0, 29) == 0),
                  1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
